// File: rtl/md5_core_param.sv
// MD5 compression engine: collects a pre-padded 512-bit block in DATA_W-bit beats,
// runs 64 steps at RPC steps per clock and chains the 128-bit state across blocks.
module md5_core_param #(
  parameter int DATA_W = 128,
  parameter int RPC    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              newtext_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic [127:0]      data_o
);

  localparam int BEATS = 512 / DATA_W;
  localparam int WPB   = DATA_W / 32;
  localparam int CW    = $clog2(BEATS);

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  if (!(DATA_W == 32 || DATA_W == 64 || DATA_W == 128)) begin : g_bad_data_w
    $error("md5_core_param: DATA_W must be 32, 64 or 128");
  end
  if (!(RPC == 1 || RPC == 2 || RPC == 4)) begin : g_bad_rpc
    $error("md5_core_param: RPC must be 1, 2 or 4");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_FINAL, S_DONE} state_t;

  function automatic logic [31:0] k_const(input logic [5:0] i);
    case (i)
      6'd0:  k_const = 32'hd76aa478;  6'd1:  k_const = 32'he8c7b756;
      6'd2:  k_const = 32'h242070db;  6'd3:  k_const = 32'hc1bdceee;
      6'd4:  k_const = 32'hf57c0faf;  6'd5:  k_const = 32'h4787c62a;
      6'd6:  k_const = 32'ha8304613;  6'd7:  k_const = 32'hfd469501;
      6'd8:  k_const = 32'h698098d8;  6'd9:  k_const = 32'h8b44f7af;
      6'd10: k_const = 32'hffff5bb1;  6'd11: k_const = 32'h895cd7be;
      6'd12: k_const = 32'h6b901122;  6'd13: k_const = 32'hfd987193;
      6'd14: k_const = 32'ha679438e;  6'd15: k_const = 32'h49b40821;
      6'd16: k_const = 32'hf61e2562;  6'd17: k_const = 32'hc040b340;
      6'd18: k_const = 32'h265e5a51;  6'd19: k_const = 32'he9b6c7aa;
      6'd20: k_const = 32'hd62f105d;  6'd21: k_const = 32'h02441453;
      6'd22: k_const = 32'hd8a1e681;  6'd23: k_const = 32'he7d3fbc8;
      6'd24: k_const = 32'h21e1cde6;  6'd25: k_const = 32'hc33707d6;
      6'd26: k_const = 32'hf4d50d87;  6'd27: k_const = 32'h455a14ed;
      6'd28: k_const = 32'ha9e3e905;  6'd29: k_const = 32'hfcefa3f8;
      6'd30: k_const = 32'h676f02d9;  6'd31: k_const = 32'h8d2a4c8a;
      6'd32: k_const = 32'hfffa3942;  6'd33: k_const = 32'h8771f681;
      6'd34: k_const = 32'h6d9d6122;  6'd35: k_const = 32'hfde5380c;
      6'd36: k_const = 32'ha4beea44;  6'd37: k_const = 32'h4bdecfa9;
      6'd38: k_const = 32'hf6bb4b60;  6'd39: k_const = 32'hbebfbc70;
      6'd40: k_const = 32'h289b7ec6;  6'd41: k_const = 32'heaa127fa;
      6'd42: k_const = 32'hd4ef3085;  6'd43: k_const = 32'h04881d05;
      6'd44: k_const = 32'hd9d4d039;  6'd45: k_const = 32'he6db99e5;
      6'd46: k_const = 32'h1fa27cf8;  6'd47: k_const = 32'hc4ac5665;
      6'd48: k_const = 32'hf4292244;  6'd49: k_const = 32'h432aff97;
      6'd50: k_const = 32'hab9423a7;  6'd51: k_const = 32'hfc93a039;
      6'd52: k_const = 32'h655b59c3;  6'd53: k_const = 32'h8f0ccc92;
      6'd54: k_const = 32'hffeff47d;  6'd55: k_const = 32'h85845dd1;
      6'd56: k_const = 32'h6fa87e4f;  6'd57: k_const = 32'hfe2ce6e0;
      6'd58: k_const = 32'ha3014314;  6'd59: k_const = 32'h4e0811a1;
      6'd60: k_const = 32'hf7537e82;  6'd61: k_const = 32'hbd3af235;
      6'd62: k_const = 32'h2ad7d2bb;  default: k_const = 32'heb86d391;
    endcase
  endfunction

  function automatic logic [4:0] shamt(input logic [5:0] i);
    case ({i[5:4], i[1:0]})
      4'h0: shamt = 5'd7;   4'h1: shamt = 5'd12;  4'h2: shamt = 5'd17;  4'h3: shamt = 5'd22;
      4'h4: shamt = 5'd5;   4'h5: shamt = 5'd9;   4'h6: shamt = 5'd14;  4'h7: shamt = 5'd20;
      4'h8: shamt = 5'd4;   4'h9: shamt = 5'd11;  4'ha: shamt = 5'd16;  4'hb: shamt = 5'd23;
      4'hc: shamt = 5'd6;   4'hd: shamt = 5'd10;  4'he: shamt = 5'd15;  default: shamt = 5'd21;
    endcase
  endfunction

  // Message word index per step; 4-bit arithmetic gives the mod-16 for free.
  function automatic logic [3:0] g_idx(input logic [5:0] i);
    logic [3:0] j;
    j = i[3:0];
    case (i[5:4])
      2'd0:    g_idx = j;
      2'd1:    g_idx = j * 4'd5 + 4'd1;
      2'd2:    g_idx = j * 4'd3 + 4'd5;
      default: g_idx = j * 4'd7;
    endcase
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] dbl;
    dbl = {x, x} << n;
    return dbl[63:32];
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [127:0] md5_step(input logic [127:0] s_in, input logic [5:0] i,
                                            input logic [31:0] m);
    logic [31:0] a, b, c, d, f, t;
    {a, b, c, d} = s_in;
    case (i[5:4])
      2'd0:    f = (b & c) | (~b & d);
      2'd1:    f = (d & b) | (~d & c);
      2'd2:    f = b ^ c ^ d;
      default: f = c ^ (b | ~d);
    endcase
    t = rotl(a + f + k_const(i) + m, shamt(i));
    return {d, b + t, b, c};
  endfunction

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [5:0]     step;
  logic [31:0]    msg [16];
  logic [31:0]    ha, hb, hc, hd;
  logic [31:0]    wa, wb, wc, wd;
  logic [31:0]    sa, sb, sc, sd;
  logic [3:0]     wr_base;
  logic           can_load, accept, last_beat, nt_ok, comp_done;

  assign can_load  = (state == S_IDLE) || (state == S_LOAD) || (state == S_DONE);
  assign accept    = load_i && can_load;
  assign last_beat = accept && (cnt == CW'(BEATS - 1));
  assign nt_ok     = newtext_i && can_load && (cnt == '0);
  assign comp_done = (state == S_COMPUTE) && (step == 6'(64 - RPC));
  assign busy_o    = (state == S_COMPUTE);
  assign wr_base   = 4'(int'(cnt) * WPB);

  assign sa = ha + wa;
  assign sb = hb + wb;
  assign sc = hc + wc;
  assign sd = hd + wd;

  // Unrolled RPC-step chain evaluated each compute cycle.
  for (genvar r = 0; r < RPC; r++) begin : g_step
    logic [127:0] st_in, st_out;
    logic [5:0]   idx;
    if (r == 0) begin : g_first
      assign st_in = {wa, wb, wc, wd};
    end else begin : g_next
      assign st_in = g_step[r-1].st_out;
    end
    assign idx    = step + 6'(r);
    assign st_out = md5_step(st_in, idx, msg[g_idx(idx)]);
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_LOAD, S_DONE: if (accept) state_nxt = last_beat ? S_COMPUTE : S_LOAD;
      S_COMPUTE:              if (comp_done) state_nxt = S_FINAL;
      S_FINAL:                state_nxt = S_DONE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      ready_o <= 1'b0;
      data_o  <= '0;
      {ha, hb, hc, hd} <= {IV_A, IV_B, IV_C, IV_D};
    end else begin
      // IV reload precedes a beat accepted in the same cycle; the two never conflict.
      if (nt_ok) begin
        {ha, hb, hc, hd} <= {IV_A, IV_B, IV_C, IV_D};
        ready_o <= 1'b0;
      end
      if (accept) begin
        cnt     <= last_beat ? '0 : cnt + CW'(1);
        ready_o <= 1'b0;
      end
      if (state == S_FINAL) begin
        {ha, hb, hc, hd} <= {sa, sb, sc, sd};
        data_o  <= {bswap(sa), bswap(sb), bswap(sc), bswap(sd)};
        ready_o <= 1'b1;
      end
    end
  end

  // Datapath: message buffer, working registers and step index carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < WPB; j++) begin
        msg[wr_base + 4'(j)] <= data_i[DATA_W-1-32*j -: 32];
      end
    end
    if (last_beat) begin
      {wa, wb, wc, wd} <= {ha, hb, hc, hd};
      step <= '0;
    end else if (state == S_COMPUTE) begin
      {wa, wb, wc, wd} <= g_step[RPC-1].st_out;
      step <= step + 6'(RPC);
    end
  end

endmodule

// File: doc/md5_core_param.md
Name: md5_core_param

Overview:
- Parametrised next-generation MD5 hashing engine.
- Accepts a pre-padded 512-bit message block as a stream of DATA_W-bit beats and runs the 64-step MD5 compression at RPC steps per clock.
- Chains intermediate state across blocks and presents the 128-bit digest in canonical byte order.
- Sits behind the message padder / host interface; software or upstream logic performs RFC 1321 padding.

Parameters:
- DATA_W, 128, load beat width in bits. Legal values are 32, 64, 128; any other value is an elaboration error. BEATS = 512/DATA_W.
- RPC, 1, MD5 steps per clock. Legal values are 1, 2, 4; any other value is an elaboration error. Compute cycles C = 64/RPC.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- load_i  input  1  beat strobe; each cycle it is high and accepted loads one beat from data_i.
- newtext_i  input  1  start-new-message strobe; reloads chaining registers with the IV.
- data_i  input  DATA_W  message beat.
- ready_o  output  1  digest valid.
- busy_o  output  1  compression in progress; beats are not accepted.
- data_o  output  128  digest, canonical byte order.

Behaviour:
- Reset (reset==0 at a rising edge):
  - Chaining regs {A,B,C,D} = 67452301, efcdab89, 98badcfe, 10325476.
  - Beat counter = 0; state = IDLE.
  - ready_o = 0, busy_o = 0, data_o = 0.
  - Reset mid-load or mid-compute discards the partial block and any in-flight result.
- Word mapping:
  - Each beat carries DATA_W/32 message words. The most-significant 32 bits hold the lowest-index word M[k].
  - Each M[k] is the RFC little-endian 32-bit integer. Example: byte "a" followed by pad byte 0x80 gives M[0] = 32'h00008061.
- States: IDLE, LOAD, COMPUTE, FINAL, DONE.
- IDLE / DONE / LOAD:
  - load_i=1 stores a beat at word slot counter*(DATA_W/32) and increments the counter.
  - The first accepted beat moves the FSM to LOAD and clears ready_o.
  - Gaps with load_i=0 are allowed; the counter holds.
- Counter wrap:
  - On the edge accepting beat BEATS-1, the counter wraps to 0, the FSM enters COMPUTE, and busy_o goes to 1.
  - Working regs a,b,c,d are loaded from the chaining regs.
- COMPUTE:
  - Performs RPC steps per cycle using the standard K[i], s[i], F/G/H/I and message index g(i).
  - i advances by RPC each cycle; all adds are modulo 2^32.
  - After C cycles the FSM enters FINAL.
  - load_i is ignored here (no effect on counter or buffer).
- FINAL (1 cycle):
  - Chaining regs += working regs, modulo 2^32 per word.
  - data_o = byte-swapped {A,B,C,D}, so data_o[127:120] is the low byte of A.
  - ready_o = 1, busy_o = 0, then DONE.
- Latency: if the last beat is accepted at edge N, ready_o and data_o are valid after edge N+C+1.
- DONE:
  - ready_o and data_o hold until the first beat of the next block is accepted (ready_o drops on that edge) or until newtext_i.
  - The next block chains from the current digest unless newtext_i intervenes.
- newtext_i:
  - Honoured only when busy_o=0 and counter==0; otherwise ignored.
  - When honoured: chaining regs = IV and ready_o = 0; data_o holds its last value.
  - If newtext_i and load_i are high in the same cycle, IV reload happens first, then the beat is accepted.
- Partial block followed by newtext_i: newtext_i is ignored because counter≠0. Recovery requires reset.

Test Plan:
- Single block "a", DATA_W=128, RPC=1:
  - Beats 128'h00008061_0..., 128'h0, 128'h0, 128'h00000000_00000000_00000008_00000000.
  - Required: data_o = 0cc175b9c0f1b6a831c399e269772661, with ready_o high exactly 65 edges after the last beat edge.
- Empty string and "abc", each preceded by newtext_i:
  - "" → d41d8cd98f00b204e9800998ecf8427e.
  - "abc" → 900150983cd24fb0d6963f7d28e17f72.
  - Confirms IV reload between messages.
- Two-block message, 80-char string "1234567890"×8, padded to 128 bytes, newtext_i before block 1 only:
  - Required: 57edf4a22be3c955ac49da2e2107b67a.
  - Omitting chaining, i.e. pulsing newtext_i before block 2, must give a different value.
- DATA_W=32, RPC=4, "abc" loaded as 16 beats with random load_i gaps:
  - Required: same digest as above, busy_o high for 16 cycles, ready_o after edge N+17.
- Robustness:
  - load_i and newtext_i toggled during COMPUTE: no effect on the digest.
  - reset low mid-COMPUTE: ready_o=0, busy_o=0, data_o=0, and a fresh "a" hash then gives 0cc175b9….
